// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter controller: FSM state encoding
// and default parameter values.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_e;

  localparam int PC_D       = 9;
  localparam int PC_L       = 5;
  localparam int PC_MAX_IDX = 16;
  localparam int PC_END_PC  = 150;

endpackage

// File: rtl/pc_ctrl.sv
// Program-counter controller: IDLE/RUN/DONE sequencer with jump-table branching.
// Optional taken-branch counter Br_cnt is present when PC_CTRL_BRCNT_EN is defined.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int D       = PC_D,
  parameter int L       = PC_L,
  parameter int MAX_IDX = PC_MAX_IDX,
  parameter int END_PC  = PC_END_PC
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         Stall,
  input  logic         Jump,
  input  logic         Taken,
  input  logic [L-1:0] Jump_idx,
  output logic [L-1:0] Lut_addr,
  input  logic [D-1:0] Target,
`ifdef PC_CTRL_BRCNT_EN
  output logic [15:0]  Br_cnt,
`endif
  output logic [D-1:0] PC,
  output logic         Running,
  output logic         Done,
  output logic         Idx_err
);

  // Extra top bit lets an index width that cannot reach MAX_IDX compare cleanly.
  localparam logic [L:0]   MAX_IDX_W = (L+1)'(MAX_IDX);
  localparam logic [D-1:0] END_PC_W  = D'(END_PC);

  pc_state_e      state_r, state_n_s;
  logic [D-1:0]   pc_r, pc_n_s, cand_s;
  logic           err_r, err_n_s;
  logic           take_s;
  logic           start_acc_s;

  // Next-state, next-PC and error-flag decode.
  always_comb begin
    state_n_s   = state_r;
    pc_n_s      = pc_r;
    err_n_s     = err_r;
    take_s      = 1'b0;
    start_acc_s = 1'b0;
    cand_s      = pc_r + D'(1);
    case (state_r)
      IDLE, DONE: begin
        if (Start) begin
          start_acc_s = 1'b1;
          pc_n_s      = '0;
          err_n_s     = 1'b0;
          state_n_s   = RUN;
        end else begin
          pc_n_s = pc_r;
        end
      end
      RUN: begin
        if (Stall) begin
          pc_n_s = pc_r;
        end else if (Jump && Taken && ({1'b0, Jump_idx} > MAX_IDX_W)) begin
          err_n_s   = 1'b1;
          state_n_s = DONE;
        end else begin
          if (Jump && Taken) begin
            cand_s = Target;
            take_s = 1'b1;
          end else begin
            cand_s = pc_r + D'(1);
          end
          pc_n_s = cand_s;
          // Reaching the end address finishes on the same edge it is loaded.
          if (cand_s == END_PC_W) begin
            state_n_s = DONE;
          end else begin
            state_n_s = RUN;
          end
        end
      end
      default: begin
        state_n_s = IDLE;
        pc_n_s    = '0;
        err_n_s   = 1'b0;
      end
    endcase
  end

  // State, PC and sticky error registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
      pc_r    <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n_s;
      pc_r    <= pc_n_s;
      err_r   <= err_n_s;
    end
  end

`ifdef PC_CTRL_BRCNT_EN
  logic [15:0] br_cnt_r;

  // Saturating count of taken legal jumps, cleared by an accepted Start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      br_cnt_r <= 16'h0000;
    end else if (start_acc_s) begin
      br_cnt_r <= 16'h0000;
    end else if (take_s && (br_cnt_r != 16'hFFFF)) begin
      br_cnt_r <= br_cnt_r + 16'h0001;
    end else begin
      br_cnt_r <= br_cnt_r;
    end
  end

  assign Br_cnt = br_cnt_r;
`endif

  assign Lut_addr = Jump_idx;
  assign PC       = pc_r;
  assign Running  = (state_r == RUN);
  assign Done     = (state_r == DONE);
  assign Idx_err  = err_r;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl; checks Br_cnt too when
// PC_CTRL_BRCNT_EN is defined.
module tb_pc_ctrl;

  localparam int D = 9;
  localparam int L = 5;

  logic         Clk;
  logic         Reset_n;
  logic         Start;
  logic         Stall;
  logic         Jump;
  logic         Taken;
  logic [L-1:0] Jump_idx;
  logic [L-1:0] Lut_addr;
  logic [D-1:0] Target;
  logic [D-1:0] PC;
  logic         Running;
  logic         Done;
  logic         Idx_err;
`ifdef PC_CTRL_BRCNT_EN
  logic [15:0]  Br_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  pc_ctrl dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Stall    (Stall),
    .Jump     (Jump),
    .Taken    (Taken),
    .Jump_idx (Jump_idx),
    .Lut_addr (Lut_addr),
    .Target   (Target),
`ifdef PC_CTRL_BRCNT_EN
    .Br_cnt   (Br_cnt),
`endif
    .PC       (PC),
    .Running  (Running),
    .Done     (Done),
    .Idx_err  (Idx_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check PC, Running, Done and Idx_err together.
  task automatic chk_all(input string tag, input int pc, input logic run, input logic dn, input logic err);
    chk({tag, ".pc"}, 32'(PC), 32'(pc));
    chk({tag, ".running"}, 32'(Running), 32'(run));
    chk({tag, ".done"}, 32'(Done), 32'(dn));
    chk({tag, ".idx_err"}, 32'(Idx_err), 32'(err));
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n  = 1'b0;
    Start    = 1'b0;
    Stall    = 1'b0;
    Jump     = 1'b0;
    Taken    = 1'b0;
    Jump_idx = 5'd3;
    Target   = 9'd0;
    step();
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0);
    chk("lut_addr3", 32'(Lut_addr), 32'd3);
    Jump_idx = 5'd17;
    #1;
    chk("lut_addr17", 32'(Lut_addr), 32'd17);
`ifdef PC_CTRL_BRCNT_EN
    chk("brcnt.reset", 32'(Br_cnt), 32'd0);
`endif
    Reset_n = 1'b1;
    step();
    chk_all("idle_hold", 0, 1'b0, 1'b0, 1'b0);

    // Start and sequential count
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk_all("start", 0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_all("seq", i, 1'b1, 1'b0, 1'b0);
    end
    step();
    step();
    chk("pc7", 32'(PC), 32'd7);

    // Not-taken jump, then jump back to 7, then taken jump to 30
    Jump = 1'b1; Taken = 1'b0; Jump_idx = 5'd1; Target = 9'd30;
    step();
    chk("not_taken", 32'(PC), 32'd8);
    Taken = 1'b1; Target = 9'd7;
    step();
    chk("jump_back", 32'(PC), 32'd7);
    Target = 9'd30;
    step();
    chk_all("taken", 30, 1'b1, 1'b0, 1'b0);

    // Stall overrides a taken jump and Start
    Stall = 1'b1; Target = 9'd60; Start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("stall", 30, 1'b1, 1'b0, 1'b0);
    end
    Start = 1'b0;
`ifdef PC_CTRL_BRCNT_EN
    chk("brcnt.stall", 32'(Br_cnt), 32'd2);
`endif
    Stall = 1'b0;

    // Illegal index
    Jump_idx = 5'd17;
    step();
    chk_all("idx_err", 30, 1'b0, 1'b1, 1'b1);
    Jump = 1'b0; Taken = 1'b0;
    step();
    chk_all("done_hold", 30, 1'b0, 1'b1, 1'b1);
`ifdef PC_CTRL_BRCNT_EN
    chk("brcnt.illegal", 32'(Br_cnt), 32'd2);
`endif
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk_all("restart", 0, 1'b1, 1'b0, 1'b0);
`ifdef PC_CTRL_BRCNT_EN
    chk("brcnt.start_clr", 32'(Br_cnt), 32'd0);
`endif

    // Jump near the end, Start ignored in RUN, run to END_PC
    Jump = 1'b1; Taken = 1'b1; Jump_idx = 5'd2; Target = 9'd140;
    step();
    Jump = 1'b0; Taken = 1'b0;
    chk("jump140", 32'(PC), 32'd140);
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk_all("start_ignored", 141, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step();
    chk_all("pc149", 149, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("end_pc", 150, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("end_hold", 150, 1'b0, 1'b1, 1'b0);
`ifdef PC_CTRL_BRCNT_EN
    chk("brcnt.one", 32'(Br_cnt), 32'd1);
`endif

    // Boundary index 16 is legal; wrap from 511 to 0
    Start = 1'b1;
    step();
    Start = 1'b0;
    Jump = 1'b1; Taken = 1'b1; Jump_idx = 5'd16; Target = 9'd510;
    step();
    Jump = 1'b0; Taken = 1'b0;
    chk_all("max_idx", 510, 1'b1, 1'b0, 1'b0);
    step();
    step();
    chk_all("wrap", 0, 1'b1, 1'b0, 1'b0);
    step();
    chk("after_wrap", 32'(PC), 32'd1);

    // Asynchronous reset mid-RUN
    #2;
    Reset_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 1'b0, 1'b0, 1'b0);
    step();
    Reset_n = 1'b1;
    step();
    step();
    chk_all("rst_no_start", 0, 1'b0, 1'b0, 1'b0);
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk_all("resume", 0, 1'b1, 1'b0, 1'b0);
    step();
    chk("resume_pc1", 32'(PC), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter D, default 9, meaning program-counter width in bits.
REQ-002 SHALL have parameter L, default 5, meaning jump-table index width in bits.
REQ-003 SHALL have parameter MAX_IDX, default 16, meaning the highest legal jump-table index.
REQ-004 SHALL have parameter END_PC, default 150, meaning the program-counter value that ends the program.
REQ-005 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port Start, input, 1 bit: single-cycle pulse that begins program execution.
REQ-008 SHALL have port Stall, input, 1 bit: holds the PC for the current cycle.
REQ-009 SHALL have port Jump, input, 1 bit: the current instruction is a jump-table branch.
REQ-010 SHALL have port Taken, input, 1 bit: the branch condition is true.
REQ-011 SHALL have port Jump_idx, input, L bits: jump-table index from the instruction.
REQ-012 SHALL have port Lut_addr, output, L bits: index driven to the external jump-target table.
REQ-013 SHALL have port Target, input, D bits: combinational table response to Lut_addr.
REQ-014 SHALL have port PC, output, D bits: current instruction address.
REQ-015 SHALL have port Running, output, 1 bit: high while in state RUN.
REQ-016 SHALL have port Done, output, 1 bit: high while in state DONE.
REQ-017 SHALL have port Idx_err, output, 1 bit: sticky flag set by an illegal taken jump.

Function
REQ-018 SHALL implement three states: IDLE, RUN, DONE.
REQ-019 In IDLE, Start=1 SHALL load PC=0 and enter RUN on the next edge.
REQ-020 In RUN with Stall=1, the PC and the state SHALL hold; Stall SHALL take priority over every other RUN input.
REQ-021 In RUN, Jump=1, Taken=1 and Jump_idx<=MAX_IDX SHALL load PC=Target on the next edge.
REQ-022 In RUN, Jump=1, Taken=1 and Jump_idx>MAX_IDX SHALL set Idx_err, hold the PC and enter DONE.
REQ-023 In RUN, every other case (no jump, or Jump=1 with Taken=0) SHALL load PC=PC+1, truncated to D bits so that it wraps.
REQ-024 In RUN, when the PC about to be loaded equals END_PC, the block SHALL load it and enter DONE on that same edge.
REQ-025 In DONE, the PC SHALL hold; Start=1 SHALL clear Idx_err, load PC=0 and re-enter RUN.
REQ-026 Lut_addr SHALL equal Jump_idx combinationally, giving zero-cycle table access.
REQ-027 Start SHALL be ignored in RUN.
REQ-028 Running and Done SHALL be decoded from the state register without extra latency.

Reset
REQ-029 Reset_n=0 SHALL asynchronously force state IDLE, PC=0 and Idx_err=0, so that Running=0 and Done=0.
REQ-030 A reset asserted mid-RUN SHALL abandon execution; restart SHALL require a new Start pulse.

Configuration
REQ-031 With macro PC_CTRL_BRCNT_EN defined, the block SHALL add output Br_cnt (16 bits), which counts taken legal jumps, saturates at 16'hFFFF, clears on reset and on Start, and holds during Stall.
REQ-032 Without PC_CTRL_BRCNT_EN, Br_cnt and its counter SHALL not exist.

Structure
REQ-033 Shared package pc_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default values of D, L, MAX_IDX and END_PC.
REQ-034 The jump-target table SHALL remain an external module; pc_ctrl SHALL contain no sub-module.

Verification
REQ-035 The bench SHALL check: reset, Start, then 5 idle cycles -> PC sequence 0,1,2,3,4,5 with Running=1.
REQ-036 The bench SHALL check: at PC=7, Jump=1, Taken=1, Jump_idx=1, Target=30 -> next PC=30; with Taken=0 -> next PC=8.
REQ-037 The bench SHALL check: Stall=1 for 3 cycles with Jump=1 and Taken=1 -> PC frozen, no branch taken, Br_cnt unchanged.
REQ-038 The bench SHALL check: Jump_idx=17 with Jump=1 and Taken=1 -> Idx_err=1, Done=1, PC held; a following Start clears Idx_err and sets PC=0.
REQ-039 The bench SHALL check: run to PC=149 with no jumps -> next PC=150, Done=1, then PC stays 150.
REQ-040 The bench SHALL check: Reset_n pulsed low mid-RUN between clock edges -> PC=0 and state IDLE immediately; a later Start resumes from 0.
